// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-lamp conflict monitor.
// The helper functions classify a 6-bit lamp command vector.
package traffic_pkg;

   typedef enum logic [1:0] {
      StStartup = 2'b00,
      StPass    = 2'b01,
      StFault   = 2'b10
   } mon_state_e;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_CONFLICT = 2'b01;
   localparam logic [1:0] FC_DARK     = 2'b10;
   localparam logic [1:0] FC_MULTI    = 2'b11;

   localparam int unsigned LAMP_MAIN_R = 0;
   localparam int unsigned LAMP_MAIN_G = 1;
   localparam int unsigned LAMP_MAIN_Y = 2;
   localparam int unsigned LAMP_SIDE_R = 3;
   localparam int unsigned LAMP_SIDE_G = 4;
   localparam int unsigned LAMP_SIDE_Y = 5;

   // Highest-priority unsafe condition present; FC_NONE when the pattern is clean.
   function automatic logic [1:0] unsafe_code(input logic [5:0] l);
      logic [2:0] m;
      logic [2:0] s;
      logic       conflict;
      logic       multi;
      logic       dark;
      m        = {l[LAMP_MAIN_Y], l[LAMP_MAIN_G], l[LAMP_MAIN_R]};
      s        = {l[LAMP_SIDE_Y], l[LAMP_SIDE_G], l[LAMP_SIDE_R]};
      conflict = (m[1] | m[2]) & (s[1] | s[2]);
      multi    = (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]) |
                 (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
      dark     = (m == 3'b000) | (s == 3'b000);
      if (conflict) begin
         return FC_CONFLICT;
      end else if (multi) begin
         return FC_MULTI;
      end else if (dark) begin
         return FC_DARK;
      end
      return FC_NONE;
   endfunction

   // Both red lamps driven by the flash phase, everything else dark.
   function automatic logic [5:0] red_only(input logic phase);
      logic [5:0] l;
      l              = '0;
      l[LAMP_MAIN_R] = phase;
      l[LAMP_SIDE_R] = phase;
      return l;
   endfunction

endpackage

// File: rtl/traffic_flash_gen.sv
// Flash phase generator: restarts lit with a zero count, then toggles every
// FLASH_HALF_CYCLES enabled cycles.
module traffic_flash_gen #(
   parameter int unsigned FLASH_HALF_CYCLES = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic phase
);

   localparam int unsigned CW = $clog2(FLASH_HALF_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_HALF_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (restart) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (enable) begin
         if (cnt_q >= CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // Next-edge phase, so the lamp registers in the parent show it without extra lag.
   assign phase = phase_d;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Fail-safe stage behind traffic_controller: passes lamp commands through,
// latches a fault on a persistent unsafe pattern and flashes all-way red.
module traffic_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned FILTER_CYCLES     = 50,
   parameter int unsigned FLASH_HALF_CYCLES = 25_000_000,
   parameter int unsigned STARTUP_CYCLES    = 150_000_000
) (
   input  logic       clk_50,
   input  logic       reset,
   input  logic       main_R,
   input  logic       main_G,
   input  logic       main_Y,
   input  logic       side_R,
   input  logic       side_G,
   input  logic       side_Y,
   input  logic       fault_clr,
   output logic       lamp_main_R,
   output logic       lamp_main_G,
   output logic       lamp_main_Y,
   output logic       lamp_side_R,
   output logic       lamp_side_G,
   output logic       lamp_side_Y,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic       flashing
);

   localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
   localparam int unsigned SW = $clog2(STARTUP_CYCLES + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_CYCLES);
   localparam logic [SW-1:0] ST_LAST  = SW'(STARTUP_CYCLES - 1);

   mon_state_e    state_q, state_d;
   logic [FW-1:0] filt_q, filt_d;
   logic [SW-1:0] st_q, st_d;
   logic          fault_q, fault_d;
   logic [1:0]    code_q, code_d;
   logic [5:0]    lamp_q, lamp_d;
   logic          flashing_q;
   logic [5:0]    cmd;
   logic [1:0]    cond_code;
   logic          unsafe;
   logic          flash_next;
   logic          flash_restart;
   logic          flash_enable;
   logic          phase;

   assign cmd[LAMP_MAIN_R] = main_R;
   assign cmd[LAMP_MAIN_G] = main_G;
   assign cmd[LAMP_MAIN_Y] = main_Y;
   assign cmd[LAMP_SIDE_R] = side_R;
   assign cmd[LAMP_SIDE_G] = side_G;
   assign cmd[LAMP_SIDE_Y] = side_Y;

   assign cond_code = unsafe_code(cmd);
   assign unsafe    = (cond_code != FC_NONE);

   always_comb begin
      state_d = state_q;
      filt_d  = '0;
      st_d    = '0;
      fault_d = fault_q;
      code_d  = code_q;
      unique case (state_q)
         StStartup: begin
            if (st_q >= ST_LAST) begin
               state_d = StPass;
            end else begin
               st_d = st_q + SW'(1);
            end
         end
         StPass: begin
            if (unsafe) begin
               filt_d = (filt_q >= FILT_MAX) ? FILT_MAX : filt_q + FW'(1);
               if (filt_d == FILT_MAX) begin
                  state_d = StFault;
                  fault_d = 1'b1;
                  code_d  = cond_code;
                  filt_d  = '0;
               end
            end
         end
         StFault: begin
            // A clear is only honoured once the inputs themselves look safe again.
            if (fault_clr && !unsafe) begin
               state_d = StStartup;
               fault_d = 1'b0;
               code_d  = FC_NONE;
            end
         end
         default: begin
            state_d = StStartup;
         end
      endcase
   end

   assign flash_next    = (state_d != StPass);
   assign flash_restart = flash_next && (state_d != state_q);
   assign flash_enable  = (state_q != StPass);
   assign lamp_d        = flash_next ? red_only(phase) : cmd;

   traffic_flash_gen #(
      .FLASH_HALF_CYCLES(FLASH_HALF_CYCLES)
   ) u_flash (
      .clk    (clk_50),
      .reset  (reset),
      .restart(flash_restart),
      .enable (flash_enable),
      .phase  (phase)
   );

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state_q    <= StStartup;
         filt_q     <= '0;
         st_q       <= '0;
         fault_q    <= 1'b0;
         code_q     <= FC_NONE;
         lamp_q     <= red_only(1'b1);
         flashing_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         filt_q     <= filt_d;
         st_q       <= st_d;
         fault_q    <= fault_d;
         code_q     <= code_d;
         lamp_q     <= lamp_d;
         flashing_q <= flash_next;
      end
   end

   assign lamp_main_R = lamp_q[LAMP_MAIN_R];
   assign lamp_main_G = lamp_q[LAMP_MAIN_G];
   assign lamp_main_Y = lamp_q[LAMP_MAIN_Y];
   assign lamp_side_R = lamp_q[LAMP_SIDE_R];
   assign lamp_side_G = lamp_q[LAMP_SIDE_G];
   assign lamp_side_Y = lamp_q[LAMP_SIDE_Y];
   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign flashing    = flashing_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with short timing parameters.
// Lamp vectors are packed {side_Y, side_G, side_R, main_Y, main_G, main_R}.
module tb_traffic_conflict_monitor;

   localparam logic [5:0] LEGAL      = 6'b001_010;
   localparam logic [5:0] CONFLICT   = 6'b010_010;
   localparam logic [5:0] CONF_MULTI = 6'b100_011;
   localparam logic [5:0] DARK_MAIN  = 6'b001_000;
   localparam logic [5:0] MULTI_DARK = 6'b000_011;
   localparam logic [5:0] ALL_RED    = 6'b001_001;
   localparam logic [5:0] ALL_OFF    = 6'b000_000;

   logic       clk_50 = 1'b0;
   logic       reset;
   logic       main_R, main_G, main_Y, side_R, side_G, side_Y;
   logic       fault_clr;
   logic       lamp_main_R, lamp_main_G, lamp_main_Y;
   logic       lamp_side_R, lamp_side_G, lamp_side_Y;
   logic       fault;
   logic [1:0] fault_code;
   logic       flashing;
   logic [5:0] lamps;

   int vectors     = 0;
   int miscompares = 0;

   traffic_conflict_monitor #(
      .FILTER_CYCLES    (4),
      .FLASH_HALF_CYCLES(8),
      .STARTUP_CYCLES   (16)
   ) dut (
      .clk_50     (clk_50),
      .reset      (reset),
      .main_R     (main_R),
      .main_G     (main_G),
      .main_Y     (main_Y),
      .side_R     (side_R),
      .side_G     (side_G),
      .side_Y     (side_Y),
      .fault_clr  (fault_clr),
      .lamp_main_R(lamp_main_R),
      .lamp_main_G(lamp_main_G),
      .lamp_main_Y(lamp_main_Y),
      .lamp_side_R(lamp_side_R),
      .lamp_side_G(lamp_side_G),
      .lamp_side_Y(lamp_side_Y),
      .fault      (fault),
      .fault_code (fault_code),
      .flashing   (flashing)
   );

   always #5 clk_50 = ~clk_50;

   assign lamps = {lamp_side_Y, lamp_side_G, lamp_side_R, lamp_main_Y, lamp_main_G, lamp_main_R};

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_50);
      #1;
   endtask

   task automatic drive(input logic [5:0] v);
      {side_Y, side_G, side_R, main_Y, main_G, main_R} = v;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_lamps"}, 8'(lamps), 8'(ALL_RED));
      check_val({tag, "_fault"}, 8'(fault), 8'd0);
      check_val({tag, "_code"}, 8'(fault_code), 8'd0);
      check_val({tag, "_flashing"}, 8'(flashing), 8'd1);
   endtask

   task automatic go_pass(input string tag);
      drive(LEGAL);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_reset_state(tag);
      step(16);
      check_val({tag, "_pass_entry"}, 8'(flashing), 8'd0);
   endtask

   initial begin
      reset     = 1'b1;
      fault_clr = 1'b0;
      drive(LEGAL);

      // 1: reset, start-up flash, PASS entry
      step(1);
      reset = 1'b0;
      check_reset_state("t1_reset");
      step(7);
      check_val("t1_lit_e7", 8'(lamps), 8'(ALL_RED));
      step(1);
      check_val("t1_dark_e8", 8'(lamps), 8'(ALL_OFF));
      step(7);
      check_val("t1_dark_e15", 8'(lamps), 8'(ALL_OFF));
      check_val("t1_flash_e15", 8'(flashing), 8'd1);
      step(1);
      check_val("t1_flash_e16", 8'(flashing), 8'd0);
      check_val("t1_sideR_e16", 8'(lamp_side_R), 8'd1);
      step(1);
      check_val("t1_pass_lamps", 8'(lamps), 8'(LEGAL));

      // 2: short conflict filtered, long conflict latches
      drive(CONFLICT);
      step(3);
      check_val("t2_short_nofault", 8'(fault), 8'd0);
      drive(LEGAL);
      step(1);
      check_val("t2_clean_nofault", 8'(fault), 8'd0);
      drive(CONFLICT);
      step(3);
      check_val("t2_3cyc_nofault", 8'(fault), 8'd0);
      step(1);
      check_val("t2_fault", 8'(fault), 8'd1);
      check_val("t2_code", 8'(fault_code), 8'd1);
      check_val("t2_flashing", 8'(flashing), 8'd1);
      check_val("t2_lit", 8'(lamps), 8'(ALL_RED));
      step(7);
      check_val("t2_lit_e7", 8'(lamps), 8'(ALL_RED));
      step(1);
      check_val("t2_dark_e8", 8'(lamps), 8'(ALL_OFF));
      check_val("t2_code_held", 8'(fault_code), 8'd1);

      // 5: reset in FAULT; 6: conflict held through start-up
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_reset_state("t5_reset_in_fault");
      step(16);
      check_val("t6_startup_nofault", 8'(fault), 8'd0);
      check_val("t6_pass_entry", 8'(flashing), 8'd0);
      step(3);
      check_val("t6_3cyc_nofault", 8'(fault), 8'd0);
      step(1);
      check_val("t6_fault", 8'(fault), 8'd1);
      check_val("t6_code", 8'(fault_code), 8'd1);

      // 3: conflict plus multi reports conflict
      go_pass("t3");
      drive(CONF_MULTI);
      step(3);
      check_val("t3_3cyc_nofault", 8'(fault), 8'd0);
      step(1);
      check_val("t3_fault", 8'(fault), 8'd1);
      check_val("t3_code", 8'(fault_code), 8'd1);

      // 4: dark fault, rejected and accepted clears
      go_pass("t4");
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      check_val("t4_clr_in_pass", 8'(fault), 8'd0);
      check_val("t4_clr_in_pass_flash", 8'(flashing), 8'd0);
      drive(DARK_MAIN);
      step(4);
      check_val("t4_fault", 8'(fault), 8'd1);
      check_val("t4_code", 8'(fault_code), 8'd2);
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      check_val("t4_clr_rejected", 8'(fault), 8'd1);
      check_val("t4_code_kept", 8'(fault_code), 8'd2);
      drive(LEGAL);
      step(1);
      check_val("t4_clr_not_remembered", 8'(fault), 8'd1);
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      check_val("t4_cleared", 8'(fault), 8'd0);
      check_val("t4_code_none", 8'(fault_code), 8'd0);
      check_val("t4_restart_flash", 8'(flashing), 8'd1);
      check_val("t4_restart_lit", 8'(lamps), 8'(ALL_RED));
      step(15);
      check_val("t4_startup_e15", 8'(flashing), 8'd1);
      step(1);
      check_val("t4_startup_e16", 8'(flashing), 8'd0);
      step(1);
      check_val("t4_pass_lamps", 8'(lamps), 8'(LEGAL));

      // multi outranks dark
      drive(MULTI_DARK);
      step(4);
      check_val("prio_fault", 8'(fault), 8'd1);
      check_val("prio_code", 8'(fault_code), 8'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
